alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked execute-stage ALU for the RISC-V core: full RV32I integer ops plus RV32M multiply/divide. Single-cycle ops complete in one cycle after acceptance. MUL/DIV run on an iterative radix-2 engine over XLEN cycles. Sits between decode/operand-read and writeback; the BEQ/BNE comparator flag is produced alongside the result.

## Interface
- XLEN, 32: operand/result width; must be even and ≥ 8.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all state.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept; high only in IDLE.
- operand_a  in  XLEN  rs1 value, sampled on accept.
- operand_b  in  XLEN  rs2/imm value, sampled on accept.
- alu_op  in  5  op code, sampled on accept (encodings in Operation).
- out_valid  out  1  result available; held until out_ready.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  registered result; stable while out_valid.
- zero_flag  out  1  registered (operand_a == operand_b) of the accepted op.
- illegal_op  out  1  accepted alu_op unsupported; result is 0.

## Operation
- Encodings:
  - 00000 ADD, 00001 SUB, 00010 SLL, 00011 SLT, 00100 SLTU, 00101 XOR, 00110 SRL, 00111 SRA, 01000 OR, 01001 AND.
  - 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU.
  - 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
  - All other codes are illegal.
- Shifts use operand_b[log2(XLEN)-1:0]. SLT/SLTU return 0 or 1.
- Arithmetic wraps modulo 2^XLEN.
- MULH* return the upper XLEN bits of the 2·XLEN product with RV signedness.
- FSM states: IDLE, CALC, DONE.
  - IDLE, accept (in_valid & in_ready):
    - single-cycle, illegal, or special-case div → DONE;
    - MUL*/DIV* otherwise → CALC with step counter = 0.
  - CALC: one iteration per cycle; after XLEN iterations → DONE.
  - DONE: out_valid=1; when out_ready → IDLE.
  - No accept in the same cycle as a DONE retire.
- Multiply: operands converted to magnitudes per signedness; shift-add; sign fixed on exit.
- Divide: restoring, magnitudes, sign fixed on exit. Quotient sign = sign(a)^sign(b); remainder sign = sign(a).
- Division special cases (no CALC):
  - divisor 0: DIV/DIVU → all ones; REM/REMU → operand_a.
  - signed overflow (a = −2^(XLEN−1), b = −1): DIV → a; REM → 0.
- Illegal op: result 0, illegal_op 1, zero_flag still valid, latency 1.
- Inputs are ignored outside IDLE. There is no cancel.

## Timing
- Reset values: in_ready 0 while rst is high, 1 in the first cycle after deassert. out_valid 0, result 0, zero_flag 0, illegal_op 0; FSM in IDLE.
- Accept at edge N:
  - single-cycle ops: out_valid from N+1;
  - MUL*/DIV*: out_valid from N+XLEN+1;
  - special-case divide: out_valid from N+1.
- Back-pressure: result, zero_flag and illegal_op are held unchanged while out_valid & !out_ready.
- Peak throughput: one single-cycle op per 2 cycles.
- rst asserted mid-CALC or in DONE: immediate return to IDLE; the pending result is discarded and out_valid drops asynchronously.

## Configuration
- ALU_DIV_EN defined: DIV/DIVU/REM/REMU are supported as above.
- ALU_DIV_EN undefined:
  - codes 10100–10111 are treated as illegal (result 0, illegal_op 1, latency 1);
  - divider datapath and its signs/special-case logic are not compiled.
- MUL* are unaffected either way.

## Structure
- Shared package alu_pkg: op-code localparams, FSM state enum, default XLEN, helper function for op class (single / mul / div / illegal).
- Sub-module alu_muldiv_iter holds the iterative engine:
  - inputs: start, magnitudes, mode;
  - outputs: done, raw product/quotient/remainder;
  - contains step counter and shift registers.
- Top holds the handshake, FSM, single-cycle datapath, sign fix-up and output registers.

## Test plan
- Reset, then ADD 0x7FFFFFFF+1 with out_ready=1 → result 0x80000000, out_valid exactly 1 cycle after accept, illegal_op 0.
- SUB 5−5 → result 0, zero_flag 1; SRA 0x80000000 by 31 → 0xFFFFFFFF; SLTU 1,0xFFFFFFFF → 1.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. Both out_valid XLEN+1 cycles after accept.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
- DIVU x/0 → 0xFFFFFFFF and DIV 0x80000000/−1 → 0x80000000, each with latency 1. Without ALU_DIV_EN, same ops → result 0, illegal_op 1.
- Hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready 0. Assert rst during CALC → out_valid 0 and in_ready 1 after release. Op 01111 → illegal_op 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: op codes, FSM states, op classing.
// The op classifier depends on ALU_DIV_EN: without it the divide codes classify as illegal.
package alu_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b00001;
  localparam logic [4:0] OP_SLL    = 5'b00010;
  localparam logic [4:0] OP_SLT    = 5'b00011;
  localparam logic [4:0] OP_SLTU   = 5'b00100;
  localparam logic [4:0] OP_XOR    = 5'b00101;
  localparam logic [4:0] OP_SRL    = 5'b00110;
  localparam logic [4:0] OP_SRA    = 5'b00111;
  localparam logic [4:0] OP_OR     = 5'b01000;
  localparam logic [4:0] OP_AND    = 5'b01001;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
  typedef enum logic [1:0] {CL_SINGLE, CL_MUL, CL_DIV, CL_ILL} op_class_e;

  function automatic op_class_e op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
      OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND:       return CL_SINGLE;
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU:        return CL_MUL;
`ifdef ALU_DIV_EN
      OP_DIV, OP_DIVU, OP_REM, OP_REMU:            return CL_DIV;
`endif
      default:                                     return CL_ILL;
    endcase
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Radix-2 iterative engine on unsigned magnitudes: shift-add multiply and, with
// ALU_DIV_EN, restoring divide. Outputs are the post-step values so the final step can be captured directly.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_div,
  input  logic [XLEN-1:0]   mag_a,
  input  logic [XLEN-1:0]   mag_b,
  output logic              done,
  output logic [2*XLEN-1:0] prod
`ifdef ALU_DIV_EN
  ,
  output logic [XLEN-1:0]   quot,
  output logic [XLEN-1:0]   rem
`endif
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] hi, lo, opb, hi_nxt, lo_nxt;
  logic [CW-1:0]   cnt;
  logic            busy;
  logic [XLEN:0]   sum;

`ifdef ALU_DIV_EN
  logic          mode_div;
  logic [XLEN:0] shl, diff;
`else
  logic unused_mode;
  assign unused_mode = is_div;
`endif

  // hi:lo is the product accumulator, or remainder:quotient while dividing
  always_comb begin
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    hi_nxt = sum[XLEN:1];
    lo_nxt = {sum[0], lo[XLEN-1:1]};
`ifdef ALU_DIV_EN
    shl  = {hi, lo[XLEN-1]};
    diff = shl - {1'b0, opb};
    if (mode_div) begin
      if (!diff[XLEN]) begin
        hi_nxt = diff[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = shl[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi   <= '0;
      lo   <= '0;
      opb  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
`ifdef ALU_DIV_EN
      mode_div <= 1'b0;
`endif
    end else if (start) begin
      hi   <= '0;
      lo   <= mag_a;
      opb  <= mag_b;
      cnt  <= '0;
      busy <= 1'b1;
`ifdef ALU_DIV_EN
      mode_div <= is_div;
`endif
    end else if (busy) begin
      hi  <= hi_nxt;
      lo  <= lo_nxt;
      cnt <= cnt + CW'(1);
      if (cnt == CW'(XLEN - 1)) busy <= 1'b0;
    end
  end

  assign done = busy && (cnt == CW'(XLEN - 1));
  assign prod = {hi_nxt, lo_nxt};
`ifdef ALU_DIV_EN
  assign quot = lo_nxt;
  assign rem  = hi_nxt;
`endif

endmodule

// File: rtl/alu_seq.sv
// Handshaked RV32IM execute ALU: FSM, single-cycle datapath, sign fix-up, output registers.
// Define ALU_DIV_EN to build the divide/remainder ops; otherwise their codes are illegal.
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      alu_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero_flag,
  output logic            illegal_op
);

  localparam int SHW = $clog2(XLEN);

  state_e          state, state_nxt;
  op_class_e       cls;
  logic            accept, start, done, special, sa, sb, neg_nxt, neg_r;
  logic [4:0]      op_r;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] single_res, sp_res, calc_res, mag_a, mag_b;
  logic [2*XLEN-1:0] prod, prod_fix;
`ifdef ALU_DIV_EN
  logic [XLEN-1:0] quot, rem, qr;
`endif

  assign cls    = op_class(alu_op);
  assign accept = in_valid && in_ready;
  assign shamt  = operand_b[SHW-1:0];

  always_comb begin
    single_res = '0;
    case (alu_op)
      OP_ADD:  single_res = operand_a + operand_b;
      OP_SUB:  single_res = operand_a - operand_b;
      OP_SLL:  single_res = operand_a << shamt;
      OP_SLT:  single_res = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
      OP_SLTU: single_res = {{(XLEN-1){1'b0}}, operand_a < operand_b};
      OP_XOR:  single_res = operand_a ^ operand_b;
      OP_SRL:  single_res = operand_a >> shamt;
      OP_SRA:  single_res = $unsigned($signed(operand_a) >>> shamt);
      OP_OR:   single_res = operand_a | operand_b;
      OP_AND:  single_res = operand_a & operand_b;
      default: single_res = '0;
    endcase
  end

  // Operand signedness per op; MUL takes the unsigned path since its low half is sign-agnostic
  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    case (alu_op)
      OP_MULH:   begin sa = operand_a[XLEN-1]; sb = operand_b[XLEN-1]; end
      OP_MULHSU: sa = operand_a[XLEN-1];
`ifdef ALU_DIV_EN
      OP_DIV, OP_REM: begin sa = operand_a[XLEN-1]; sb = operand_b[XLEN-1]; end
`endif
      default: ;
    endcase
    mag_a   = sa ? -operand_a : operand_a;
    mag_b   = sb ? -operand_b : operand_b;
    neg_nxt = (alu_op == OP_REM) ? sa : (sa ^ sb);
  end

`ifdef ALU_DIV_EN
  always_comb begin
    special = 1'b0;
    sp_res  = '0;
    if (cls == CL_DIV) begin
      if (operand_b == '0) begin
        special = 1'b1;
        sp_res  = (alu_op == OP_DIV || alu_op == OP_DIVU) ? '1 : operand_a;
      end else if ((alu_op == OP_DIV || alu_op == OP_REM) &&
                   operand_a == {1'b1, {(XLEN-1){1'b0}}} && operand_b == '1) begin
        special = 1'b1;
        sp_res  = (alu_op == OP_DIV) ? operand_a : '0;
      end
    end
  end
`else
  assign special = 1'b0;
  assign sp_res  = '0;
`endif

  assign start = accept && (cls == CL_MUL || (cls == CL_DIV && !special));

  alu_muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .is_div (cls == CL_DIV),
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .done   (done),
    .prod   (prod)
`ifdef ALU_DIV_EN
    ,
    .quot   (quot),
    .rem    (rem)
`endif
  );

  always_comb begin
    prod_fix = neg_r ? -prod : prod;
    calc_res = (op_r == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
`ifdef ALU_DIV_EN
    qr = op_r[1] ? rem : quot;
    if (op_r[2]) calc_res = neg_r ? -qr : qr;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = start ? S_CALC : S_DONE;
      S_CALC: if (done) state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE) && !rst;
    out_valid = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result     <= '0;
      zero_flag  <= 1'b0;
      illegal_op <= 1'b0;
      op_r       <= '0;
      neg_r      <= 1'b0;
    end else if (accept) begin
      op_r       <= alu_op;
      neg_r      <= neg_nxt;
      zero_flag  <= (operand_a == operand_b);
      illegal_op <= (cls == CL_ILL);
      if (!start) result <= (cls == CL_SINGLE) ? single_res : (special ? sp_res : '0);
    end else if (state == S_CALC && done) begin
      result <= calc_res;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (XLEN=32); expectations follow ALU_DIV_EN.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] operand_a = '0;
  logic [XLEN-1:0] operand_b = '0;
  logic [4:0]      alu_op = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic            zero_flag;
  logic            illegal_op;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    logic        ill;
  } vec_t;

  always #5 clk = ~clk;

  alu_seq #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .alu_op     (alu_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero_flag  (zero_flag),
    .illegal_op (illegal_op)
  );

  // Issue one op with out_ready high; lat = edges from accept to first edge seeing out_valid (-1 on timeout)
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic zf, output logic ill);
    int guard = 0;
    out_ready = 1'b1;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    alu_op = op; operand_a = a; operand_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!out_valid) lat = -1;
    res = result; zf = zero_flag; ill = illegal_op;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== 32'h0 ||
        zero_flag !== 1'b0 || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h zf=%b ill=%b, want 0 0 0 0 0",
               in_ready, out_valid, result, zero_flag, illegal_op);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_vectors(input string name, input vec_t v[$]);
    int lat; logic [31:0] res; logic zf, ill;
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, lat, res, zf, ill);
      checks++;
      if (res !== v[i].exp || lat != v[i].lat || ill !== v[i].ill) begin
        errors++;
        $display("FAIL %s[%0d] op=%b a=%h b=%h: result=%h lat=%0d ill=%b, want result=%h lat=%0d ill=%b",
                 name, i, v[i].op, v[i].a, v[i].b, res, lat, ill, v[i].exp, v[i].lat, v[i].ill);
      end
    end
  endtask

  task automatic test_single();
    vec_t v[$];
    int lat; logic [31:0] res; logic zf, ill;
    v.push_back('{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1, 1'b0});
    v.push_back('{OP_SRA,  32'h80000000, 32'd31,       32'hFFFFFFFF, 1, 1'b0});
    v.push_back('{OP_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1, 1'b0});
    v.push_back('{OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1, 1'b0});
    v.push_back('{OP_SLL,  32'h00000001, 32'd35,       32'h00000008, 1, 1'b0});
    v.push_back('{OP_SRL,  32'h80000000, 32'd4,        32'h08000000, 1, 1'b0});
    v.push_back('{OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1, 1'b0});
    v.push_back('{OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1, 1'b0});
    v.push_back('{OP_OR,   32'hF0F0F0F0, 32'h0000000F, 32'hF0F0F0FF, 1, 1'b0});
    test_vectors("single", v);
    run_op(OP_SUB, 32'd5, 32'd5, lat, res, zf, ill);
    checks++;
    if (res !== 32'h0 || zf !== 1'b1 || lat != 1) begin
      errors++;
      $display("FAIL sub_zero: result=%h zf=%b lat=%0d, want 0 1 1", res, zf, lat);
    end
  endtask

  task automatic test_mul();
    vec_t v[$];
    v.push_back('{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, XLEN+1, 1'b0});
    v.push_back('{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, XLEN+1, 1'b0});
    v.push_back('{OP_MUL,    32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFFA, XLEN+1, 1'b0});
    v.push_back('{OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, XLEN+1, 1'b0});
    test_vectors("mul", v);
  endtask

  task automatic test_div();
    vec_t v[$];
`ifdef ALU_DIV_EN
    v.push_back('{OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, XLEN+1, 1'b0});
    v.push_back('{OP_REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, XLEN+1, 1'b0});
    v.push_back('{OP_DIVU, 32'd100,      32'd7,        32'd14,       XLEN+1, 1'b0});
    v.push_back('{OP_REMU, 32'd100,      32'd7,        32'd2,        XLEN+1, 1'b0});
    v.push_back('{OP_DIVU, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1,      1'b0});
    v.push_back('{OP_REM,  32'h00001234, 32'h00000000, 32'h00001234, 1,      1'b0});
    v.push_back('{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,      1'b0});
    v.push_back('{OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,      1'b0});
`else
    v.push_back('{OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'h00000000, 1, 1'b1});
    v.push_back('{OP_REMU, 32'd100,      32'd7,        32'h00000000, 1, 1'b1});
    v.push_back('{OP_DIVU, 32'h00001234, 32'h00000000, 32'h00000000, 1, 1'b1});
    v.push_back('{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1'b1});
`endif
    test_vectors("div", v);
  endtask

  task automatic test_illegal();
    int lat; logic [31:0] res; logic zf, ill;
    run_op(5'b01111, 32'd9, 32'd9, lat, res, zf, ill);
    checks++;
    if (res !== 32'h0 || ill !== 1'b1 || zf !== 1'b1 || lat != 1) begin
      errors++;
      $display("FAIL illegal_op: result=%h ill=%b zf=%b lat=%0d, want 0 1 1 1", res, ill, zf, lat);
    end
    run_op(OP_ADD, 32'd1, 32'd2, lat, res, zf, ill);
    checks++;
    if (res !== 32'd3 || ill !== 1'b0 || zf !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clears: result=%h ill=%b zf=%b, want 3 0 0", res, ill, zf);
    end
  endtask

  task automatic test_backpressure();
    int guard = 0;
    out_ready = 1'b0;
    alu_op = OP_ADD; operand_a = 32'd3; operand_b = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    alu_op = OP_SUB; operand_a = 32'd8; operand_b = 32'd8;
    while (!out_valid && guard < 100) begin @(posedge clk); #1; guard++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd7 ||
          zero_flag !== 1'b0 || illegal_op !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: out_valid=%b in_ready=%b result=%h zf=%b ill=%b, want 1 0 7 0 0",
                 i, out_valid, in_ready, result, zero_flag, illegal_op);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL retire: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int gap = 0;
    out_ready = 1'b1;
    alu_op = OP_ADD; operand_a = 32'd10; operand_b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    operand_a = 32'd1; operand_b = 32'd1;
    while (!in_ready && gap < 10) begin @(posedge clk); #1; gap++; end
    checks++;
    if (result !== 32'd30 || gap != 1) begin
      errors++;
      $display("FAIL back_to_back_first: result=%h gap=%0d, want 1e 1", result, gap);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd2) begin
      errors++;
      $display("FAIL back_to_back_second: out_valid=%b result=%h, want 1 2", out_valid, result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_calc();
    int lat; logic [31:0] res; logic zf, ill;
    alu_op = OP_MULHU; operand_a = 32'hFFFFFFFF; operand_b = 32'hFFFFFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_calc: out_valid=%b in_ready=%b result=%h, want 0 0 0", out_valid, in_ready, result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    repeat (XLEN + 4) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_discard: out_valid=%b want 0", out_valid);
      end
    end
    run_op(OP_MULH, 32'hFFFFFFFE, 32'h00000003, lat, res, zf, ill);
    checks++;
    if (res !== 32'hFFFFFFFF || lat != XLEN + 1) begin
      errors++;
      $display("FAIL post_rst_mul: result=%h lat=%0d, want ffffffff %0d", res, lat, XLEN + 1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mul();
    test_div();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_calc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
